// File: rtl/vga_pattern_anim_pkg.sv
// vga_pkg: shared constants and types for the VGA pattern/animation block.
//   - 12-bit {R,G,B} colour constants (4 bits per channel)
//   - pattern mode encodings selected by the board switches
//   - per-axis bounce direction
//   - default 640x480 timing constants
package vga_pkg;

  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] BLUE   = 12'h00F;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] WHITE  = 12'hFFF;

  typedef enum logic [2:0] {
    MODE_SOLID    = 3'b000,
    MODE_STRIPE   = 3'b001,
    MODE_CORNER   = 3'b010,
    MODE_BAR      = 3'b011,
    MODE_VBOUNCE  = 3'b100,
    MODE_BOUNCE2D = 3'b101,
    MODE_CHECK    = 3'b110,
    MODE_OFF      = 3'b111
  } mode_e;

  typedef enum logic {
    FWD = 1'b0,
    REV = 1'b1
  } dir_e;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned H_TOTAL_DEF  = 800;
  localparam int unsigned V_TOTAL_DEF  = 525;

endpackage

// File: rtl/bounce_axis.sv
// bounce_axis: one axis of the bouncing block.
//   clk_25mhz   in   pixel clock
//   reset       in   synchronous active-low reset
//   en          in   one position update this cycle
//   hold_centre in   on an update, force pos to CENTRE and keep direction
//   pos         out  current edge position (11-bit)
//   dir         out  current direction (FWD = increasing)
// Range is 0..MAX; the clamp at either end and the direction flip happen on
// the same update, and every compare precedes the subtraction so there is
// no unsigned wrap-around.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int unsigned MAX    = 608,
  parameter int unsigned STEP   = 2,
  parameter int unsigned INIT   = 0,
  parameter int unsigned CENTRE = 0
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        en,
  input  logic        hold_centre,
  output logic [10:0] pos,
  output dir_e        dir
);

  logic [10:0] pos_q, pos_d;
  dir_e        dir_q, dir_d;
  logic [11:0] fwd_sum;

  assign fwd_sum = {1'b0, pos_q} + 12'(STEP);

  always_ff @(posedge clk_25mhz) begin
    if (!reset) begin
      pos_q <= 11'(INIT);
      dir_q <= FWD;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (en) begin
      if (hold_centre) begin
        pos_d = 11'(CENTRE);
      end else begin
        unique case (dir_q)
          FWD: begin
            if (fwd_sum > 12'(MAX)) begin
              pos_d = 11'(MAX);
              dir_d = REV;
            end else begin
              pos_d = fwd_sum[10:0];
            end
          end
          REV: begin
            if (pos_q < 11'(STEP)) begin
              pos_d = '0;
              dir_d = FWD;
            end else begin
              pos_d = pos_q - 11'(STEP);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;

endmodule

// File: rtl/vga_pattern_anim.sv
// vga_pattern_anim: switch-selected VGA test patterns with a bouncing block.
//   clk_25mhz       in   pixel clock
//   reset           in   synchronous active-low reset
//   mode[2:0]       in   pattern select (board switches)
//   pause           in   freezes animation while high
//   hCount/vCount   in   pixel column / line from the VGA controller
//   blank           in   high outside the visible area
//   vgaRed/Green/Blue out registered colour, 1 cycle after hCount/vCount/blank
//   frame_tick      out  1-cycle pulse at the start of vertical blank
//   block_x/block_y out  top-left corner of the moving block
// Block position only changes on the frame tick (vertical blank), so a
// frame is never drawn with a half-moved block.
module vga_pattern_anim
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned CW          = 4,
  parameter int unsigned STRIPE_LOG2 = 4,
  parameter int unsigned CORNER_SIZE = 128,
  parameter int unsigned BLOCK_SIZE  = 32,
  parameter int unsigned STEP        = 2,
  parameter int unsigned FRAME_DIV   = 1
) (
  input  logic          clk_25mhz,
  input  logic          reset,
  input  logic [2:0]    mode,
  input  logic          pause,
  input  logic [10:0]   hCount,
  input  logic [10:0]   vCount,
  input  logic          blank,
  output logic [CW-1:0] vgaRed,
  output logic [CW-1:0] vgaGreen,
  output logic [CW-1:0] vgaBlue,
  output logic          frame_tick,
  output logic [10:0]   block_x,
  output logic [10:0]   block_y
);

  localparam int unsigned XMAX   = H_ACTIVE - BLOCK_SIZE;
  localparam int unsigned YMAX   = V_ACTIVE - BLOCK_SIZE;
  localparam int unsigned XCTR   = XMAX / 2;
  localparam int unsigned DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  // Channels are full-scale or zero, so only one on/off flag per channel
  // is carried through the pipeline register.
  localparam logic [2:0] F_BLACK  = {BLACK[11],  BLACK[7],  BLACK[3]};
  localparam logic [2:0] F_RED    = {RED[11],    RED[7],    RED[3]};
  localparam logic [2:0] F_GREEN  = {GREEN[11],  GREEN[7],  GREEN[3]};
  localparam logic [2:0] F_BLUE   = {BLUE[11],   BLUE[7],   BLUE[3]};
  localparam logic [2:0] F_YELLOW = {YELLOW[11], YELLOW[7], YELLOW[3]};
  localparam logic [2:0] F_WHITE  = {WHITE[11],  WHITE[7],  WHITE[3]};

  mode_e            mode_w;
  logic             tick_w, anim_w, qualify_w, upd_w, vbounce_w;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q;
  logic [2:0]       rgb_q, rgb_d;
  logic             in_block_w;
  dir_e             unused_x_dir, unused_y_dir;

  assign mode_w    = mode_e'(mode);
  assign tick_w    = (hCount == 11'd0) && (vCount == 11'(V_ACTIVE));
  assign vbounce_w = (mode_w == MODE_VBOUNCE);
  assign anim_w    = vbounce_w || (mode_w == MODE_BOUNCE2D);
  assign qualify_w = tick_w && anim_w && !pause;
  assign upd_w     = qualify_w && (div_q == DIV_W'(FRAME_DIV - 1));

  always_comb begin
    div_d = div_q;
    if (qualify_w) div_d = upd_w ? '0 : div_q + 1'b1;
  end

  bounce_axis #(
    .MAX    (XMAX),
    .STEP   (STEP),
    .INIT   (XCTR),
    .CENTRE (XCTR)
  ) u_x (
    .clk_25mhz   (clk_25mhz),
    .reset       (reset),
    .en          (upd_w),
    .hold_centre (vbounce_w),
    .pos         (block_x),
    .dir         (unused_x_dir)
  );

  bounce_axis #(
    .MAX    (YMAX),
    .STEP   (STEP),
    .INIT   (0),
    .CENTRE (0)
  ) u_y (
    .clk_25mhz   (clk_25mhz),
    .reset       (reset),
    .en          (upd_w),
    .hold_centre (1'b0),
    .pos         (block_y),
    .dir         (unused_y_dir)
  );

  // 12-bit compares so block_x + BLOCK_SIZE cannot overflow.
  assign in_block_w = ({1'b0, hCount} >= {1'b0, block_x}) &&
                      ({1'b0, hCount} <  {1'b0, block_x} + 12'(BLOCK_SIZE)) &&
                      ({1'b0, vCount} >= {1'b0, block_y}) &&
                      ({1'b0, vCount} <  {1'b0, block_y} + 12'(BLOCK_SIZE));

  always_comb begin
    rgb_d = F_BLACK;
    if (!blank) begin
      unique case (mode_w)
        MODE_SOLID:    rgb_d = F_YELLOW;
        MODE_STRIPE:   rgb_d = hCount[STRIPE_LOG2] ? F_WHITE : F_RED;
        MODE_CORNER:   rgb_d = ((hCount >= 11'(H_ACTIVE - CORNER_SIZE)) &&
                                (vCount <  11'(CORNER_SIZE))) ? F_GREEN : F_BLACK;
        MODE_BAR:      rgb_d = (vCount >= 11'(V_ACTIVE - 32)) ? F_BLUE : F_BLACK;
        MODE_VBOUNCE,
        MODE_BOUNCE2D: rgb_d = in_block_w ? F_WHITE : F_BLACK;
        MODE_CHECK:    rgb_d = (hCount[5] ^ vCount[5]) ? F_WHITE : F_BLACK;
        MODE_OFF:      rgb_d = F_BLACK;
        default:       rgb_d = F_BLACK;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (!reset) begin
      rgb_q  <= '0;
      tick_q <= 1'b0;
      div_q  <= '0;
    end else begin
      rgb_q  <= rgb_d;
      tick_q <= tick_w;
      div_q  <= div_d;
    end
  end

  assign vgaRed     = {CW{rgb_q[2]}};
  assign vgaGreen   = {CW{rgb_q[1]}};
  assign vgaBlue    = {CW{rgb_q[0]}};
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_pattern_anim.sv
module tb_vga_pattern_anim;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mode;
  logic        pause;
  logic [10:0] hc, vc;
  logic        blank;

  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        tick_a, tick_b;
  logic [10:0] x_a, y_a, x_b, y_b;

  always #20 clk = ~clk;

  vga_pattern_anim dut_a (
    .clk_25mhz (clk), .reset (reset), .mode (mode), .pause (pause),
    .hCount (hc), .vCount (vc), .blank (blank),
    .vgaRed (r_a), .vgaGreen (g_a), .vgaBlue (b_a),
    .frame_tick (tick_a), .block_x (x_a), .block_y (y_a)
  );

  vga_pattern_anim #(.FRAME_DIV (3)) dut_b (
    .clk_25mhz (clk), .reset (reset), .mode (mode), .pause (pause),
    .hCount (hc), .vCount (vc), .blank (blank),
    .vgaRed (r_b), .vgaGreen (g_b), .vgaBlue (b_b),
    .frame_tick (tick_b), .block_x (x_b), .block_y (y_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Tick counters sampled on the clock edge following the pulse.
  int ticks_a = 0, ticks_b = 0;
  always @(posedge clk) begin
    if (tick_a === 1'b1) ticks_a++;
    if (tick_b === 1'b1) ticks_b++;
  end

  // Colour scoreboard: expected colour pushed when a pixel is driven,
  // compared one clock later.
  logic [11:0] exp_q[$];
  string       tag_q[$];

  task automatic px(input logic [10:0] h, input logic [10:0] v, input logic b,
                    input logic [11:0] e);
    @(negedge clk);
    if (exp_q.size() > 0) chk(tag_q.pop_front(), {r_a, g_a, b_a}, exp_q.pop_front());
    hc = h; vc = v; blank = b;
    exp_q.push_back(e);
    tag_q.push_back($sformatf("pix m%0d h%0d v%0d b%0d", mode, h, v, b));
  endtask

  task automatic flush();
    @(negedge clk);
    while (exp_q.size() > 0) chk(tag_q.pop_front(), {r_a, g_a, b_a}, exp_q.pop_front());
  endtask

  // Position model: index 0 = FRAME_DIV 1, index 1 = FRAME_DIV 3.
  int mx[2], my[2], dx[2], dy[2], md[2];
  int fdiv[2] = '{1, 3};

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 304; my[i] = 0; dx[i] = 1; dy[i] = 1; md[i] = 0;
    end
  endfunction

  function automatic void axis_step(inout int p, inout int d, input int lim);
    int np;
    np = p + d * 2;
    if (np > lim)    begin p = lim; d = -1; end
    else if (np < 0) begin p = 0;   d = 1;  end
    else p = np;
  endfunction

  function automatic void model_frame();
    for (int i = 0; i < 2; i++) begin
      if ((mode == 3'd4 || mode == 3'd5) && !pause) begin
        md[i]++;
        if (md[i] == fdiv[i]) begin
          md[i] = 0;
          if (mode == 3'd4) mx[i] = 304;
          else axis_step(mx[i], dx[i], 608);
          axis_step(my[i], dy[i], 448);
        end
      end
    end
  endfunction

  task automatic frame();
    @(negedge clk); hc = 11'd0; vc = 11'd480; blank = 1'b1;
    @(negedge clk); hc = 11'd1;
    @(negedge clk);
    model_frame();
  endtask

  task automatic check_pos(input string tag);
    chk({tag, " x_a"}, x_a, mx[0]);
    chk({tag, " y_a"}, y_a, my[0]);
    chk({tag, " x_b"}, x_b, mx[1]);
    chk({tag, " y_b"}, y_b, my[1]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; hc = 11'd100; vc = 11'd100; blank = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0a, t0b, sx, sy;
    logic [10:0] hh;
    logic saw_x, saw_y, y_bad;

    reset = 1'b0; mode = 3'd5; pause = 1'b0;
    hc = 11'd100; vc = 11'd100; blank = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst x_a", x_a, 304);
    chk("rst y_a", y_a, 0);
    chk("rst x_b", x_b, 304);
    chk("rst rgb", {r_a, g_a, b_a}, 0);
    chk("rst tick", tick_a, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("post-rst rgb", {r_a, g_a, b_a}, 0);
    chk("post-rst x_a", x_a, 304);

    // Stripes: 16-pixel red/white bands.
    mode = 3'd1;
    for (int h = 0; h < 48; h++) begin
      hh = 11'(h);
      px(hh, 11'd10, 1'b0, hh[4] ? 12'hFFF : 12'hF00);
    end
    flush();

    mode = 3'd0;
    px(11'd5, 11'd5, 1'b1, 12'h000);
    px(11'd5, 11'd5, 1'b0, 12'hFF0);
    px(11'd600, 11'd400, 1'b1, 12'h000);
    flush();

    mode = 3'd2;
    px(11'd511, 11'd0,   1'b0, 12'h000);
    px(11'd512, 11'd0,   1'b0, 12'h0F0);
    px(11'd639, 11'd127, 1'b0, 12'h0F0);
    px(11'd639, 11'd128, 1'b0, 12'h000);
    flush();

    mode = 3'd3;
    px(11'd0, 11'd447, 1'b0, 12'h000);
    px(11'd0, 11'd448, 1'b0, 12'h00F);
    px(11'd9, 11'd479, 1'b0, 12'h00F);
    flush();

    mode = 3'd6;
    px(11'd32, 11'd0,  1'b0, 12'hFFF);
    px(11'd32, 11'd32, 1'b0, 12'h000);
    px(11'd0,  11'd0,  1'b0, 12'h000);
    px(11'd0,  11'd32, 1'b0, 12'hFFF);
    flush();

    mode = 3'd7;
    px(11'd100, 11'd100, 1'b0, 12'h000);
    flush();

    // Block pixels at the reset position (304,0).
    mode = 3'd5;
    px(11'd304, 11'd0,  1'b0, 12'hFFF);
    px(11'd335, 11'd31, 1'b0, 12'hFFF);
    px(11'd336, 11'd0,  1'b0, 12'h000);
    px(11'd303, 11'd0,  1'b0, 12'h000);
    px(11'd304, 11'd32, 1'b0, 12'h000);
    px(11'd304, 11'd0,  1'b1, 12'h000);
    flush();

    // 2-D bounce over 400 frames.
    saw_x = 1'b0; saw_y = 1'b0; y_bad = 1'b0;
    t0a = ticks_a;
    for (int f = 0; f < 400; f++) begin
      frame();
      check_pos($sformatf("bounce f%0d", f));
      if (x_a == 11'd608) saw_x = 1'b1;
      if (y_a == 11'd448) saw_y = 1'b1;
      if (y_a > 11'd448)  y_bad = 1'b1;
    end
    chk("x reached 608", saw_x, 1);
    chk("y reached 448", saw_y, 1);
    chk("y in range", y_bad, 0);
    chk("ticks 400", ticks_a - t0a, 400);

    // Vertical bounce with frame divider 3 on dut_b.
    do_reset();
    mode = 3'd4;
    for (int f = 0; f < 9; f++) frame();
    check_pos("vbounce");
    chk("vb x_b", x_b, 304);
    chk("vb y_b", y_b, 6);
    chk("vb y_a", y_a, 18);

    // Pause.
    mode = 3'd5;
    for (int f = 0; f < 3; f++) frame();
    check_pos("pre-pause");
    sx = mx[0]; sy = my[0];
    pause = 1'b1;
    t0a = ticks_a; t0b = ticks_b;
    for (int f = 0; f < 5; f++) begin
      frame();
      check_pos($sformatf("paused f%0d", f));
    end
    chk("paused ticks_a", ticks_a - t0a, 5);
    chk("paused ticks_b", ticks_b - t0b, 5);
    chk("paused x_a hold", x_a, sx);
    pause = 1'b0;
    frame();
    check_pos("resume");
    chk("resume y_a moved", y_a, sy + 2);

    // Static mode between animated runs keeps the stored position.
    mode = 3'd3;
    for (int f = 0; f < 4; f++) begin
      frame();
      check_pos($sformatf("static f%0d", f));
    end
    mode = 3'd5;
    frame();
    check_pos("back to 2d");
    px(11'(mx[0]), 11'(my[0]), 1'b0, 12'hFFF);
    px(11'(mx[0] + 32), 11'(my[0]), 1'b0, 12'h000);
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
